// File: rtl/bch_pkg.sv
// ---------------------------------------------------------------------------
// bch_pkg
// Shared constants and types for the BCH(63,51) transmit path.
//   BCH_N / BCH_K / BCH_R : codeword length, data length, parity length
//   bch_sched_state_t     : scheduler FSM states
// ---------------------------------------------------------------------------
package bch_pkg;

  localparam int BCH_N = 63;
  localparam int BCH_K = 51;
  localparam int BCH_R = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } bch_sched_state_t;

endpackage

// File: rtl/bch_tx_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational requester selection for the BCH scheduler.
//   req     in   N_REQ  request vector
//   ptr     in   PTR_W  round-robin search start index (0..N_REQ-1)
//   en      in   1      grant enable; gnt is all-zero when low
//   gnt     out  N_REQ  one-hot grant
//   gnt_idx out  PTR_W  index of the selected requester (valid when |gnt)
// Build option BCH_SCHED_PRIORITY_EN: when defined, lowest asserted index
// always wins and ptr is ignored; otherwise round-robin starting at ptr.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  logic [N_REQ-1:0] gnt_raw;

`ifdef BCH_SCHED_PRIORITY_EN
  logic ptr_unused;
  assign ptr_unused = ^ptr;

  // Scan from the top down so the lowest asserted index is the last write.
  always_comb begin
    gnt_raw = '0;
    gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt_raw    = '0;
        gnt_raw[k] = 1'b1;
        gnt_idx    = PTR_W'(k);
      end
    end
  end
`else
  logic [PTR_W:0]   cand_wide;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Visit ptr, ptr+1, ... wrapping at N_REQ; the first asserted one wins.
  always_comb begin
    gnt_raw   = '0;
    gnt_idx   = '0;
    found     = 1'b0;
    cand_wide = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_wide = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand_wide >= (PTR_W+1)'(N_REQ)) begin
        cand_wide = cand_wide - (PTR_W+1)'(N_REQ);
      end
      cand = cand_wide[PTR_W-1:0];
      if (!found && req[cand]) begin
        found         = 1'b1;
        gnt_raw[cand] = 1'b1;
        gnt_idx       = cand;
      end
    end
  end
`endif

  assign gnt = en ? gnt_raw : '0;

endmodule

// File: rtl/bch_tx_scheduler.sv
// ---------------------------------------------------------------------------
// bch_tx_scheduler
// Shares one serial BCH(63,51) encoder between N_REQ block requesters:
// grants one requester per codeword, shifts its 51-bit block MSB-first into
// the encoder, then forwards the 63 encoded bits with sof/eof and owner id.
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   req_valid     in   N_REQ       requester i has a block ready
//   req_data      in   N_REQ*51    block i at [i*51 +: 51], bit 50 first
//   req_ready     out  N_REQ       one-hot grant/accept strobe (IDLE only)
//   enc_valid     out  data bit valid toward encoder
//   enc_bit       out  data bit toward encoder
//   enc_ready_in  in   encoder accepts a data bit
//   enc_ready_out out  downstream ready forwarded to the encoder (= m_ready)
//   enc_out_valid in   encoder output bit valid
//   enc_out_bit   in   encoder output bit
//   m_valid/m_bit out  encoded stream downstream
//   m_ready       in   downstream accepts bit
//   m_sof/m_eof   out  first / 63rd bit of the codeword
//   m_id          out  ID_W  requester owning the current codeword
//   err_stray     out  sticky: encoder output seen while IDLE
// Build option BCH_SCHED_PRIORITY_EN selects fixed priority arbitration
// (handled inside rr_arbiter); default is round-robin.
// ---------------------------------------------------------------------------
module bch_tx_scheduler
  import bch_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*BCH_K-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   enc_valid,
  output logic                   enc_bit,
  input  logic                   enc_ready_in,
  output logic                   enc_ready_out,
  input  logic                   enc_out_valid,
  input  logic                   enc_out_bit,
  output logic                   m_valid,
  output logic                   m_bit,
  input  logic                   m_ready,
  output logic                   m_sof,
  output logic                   m_eof,
  output logic [ID_W-1:0]        m_id,
  output logic                   err_stray
);

  localparam int         PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [5:0] IN_LAST  = 6'(BCH_K - 1);
  localparam logic [5:0] OUT_LAST = 6'(BCH_N - 1);

  bch_sched_state_t state_reg;
  logic [BCH_K-1:0] sh_reg;
  logic [5:0]       in_cnt_reg;
  logic [5:0]       out_cnt_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [ID_W-1:0]  id_reg;
  logic             err_reg;

  logic [BCH_K-1:0] req_word [N_REQ];
  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] ptr_next;
  logic             arb_en;
  logic             busy;
  logic             grant_hs;
  logic             in_hs;
  logic             out_hs;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*BCH_K +: BCH_K];
    end
  endgenerate

  // Gating with rst keeps req_ready low while reset is asserted, even though
  // the state is already IDLE then.
  assign arb_en = (state_reg == IDLE) && rst;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_reg),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign grant_hs  = |gnt;  // gnt only ever selects an asserted request
  assign ptr_next  = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign busy          = (state_reg != IDLE);
  assign enc_valid     = (state_reg == SHIFT);
  assign enc_bit       = enc_valid & sh_reg[BCH_K-1];
  assign in_hs         = enc_valid & enc_ready_in;
  assign enc_ready_out = m_ready;

  // Encoder output is only forwarded while a codeword is owned.
  assign m_valid   = busy & enc_out_valid;
  assign m_bit     = busy & enc_out_bit;
  assign out_hs    = m_valid & m_ready;
  assign m_sof     = busy && (out_cnt_reg == 6'd0);
  assign m_eof     = busy && (out_cnt_reg == OUT_LAST);
  assign m_id      = id_reg;
  assign err_stray = err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      sh_reg      <= '0;
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      ptr_reg     <= '0;
      id_reg      <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (!busy && enc_out_valid) begin
        err_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (grant_hs) begin
            sh_reg      <= req_word[gnt_idx];
            id_reg      <= ID_W'(gnt_idx);
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
            ptr_reg     <= ptr_next;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          if (in_hs) begin
            sh_reg <= {sh_reg[BCH_K-2:0], 1'b0};
            if (in_cnt_reg == IN_LAST) begin
              state_reg <= DRAIN;
            end else begin
              in_cnt_reg <= in_cnt_reg + 6'd1;
            end
          end
        end
        DRAIN: begin
          if (out_hs && (out_cnt_reg == OUT_LAST)) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // out_hs is never true in IDLE, so this cannot collide with the clear.
      if (out_hs && (out_cnt_reg != OUT_LAST)) begin
        out_cnt_reg <= out_cnt_reg + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_bch_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bch_tx_scheduler
// Directed sequence with randomized data/handshakes against a reference
// model of the scheduler's rules plus a behavioural serial encoder.
// ---------------------------------------------------------------------------
module tb_bch_tx_scheduler;
  import bch_pkg::*;

  localparam int          N     = 3;
  localparam int          IDW   = 3;
  localparam logic [12:0] GPOLY = 13'h1539;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*51-1:0]  req_data;
  logic [N-1:0]     req_ready;
  logic             enc_valid;
  logic             enc_bit;
  logic             enc_ready_in;
  logic             enc_ready_out;
  logic             enc_out_valid;
  logic             enc_out_bit;
  logic             m_valid;
  logic             m_bit;
  logic             m_ready;
  logic             m_sof;
  logic             m_eof;
  logic [IDW-1:0]   m_id;
  logic             err_stray;

  bch_tx_scheduler #(.N_REQ(N), .ID_W(IDW)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .enc_valid     (enc_valid),
    .enc_bit       (enc_bit),
    .enc_ready_in  (enc_ready_in),
    .enc_ready_out (enc_ready_out),
    .enc_out_valid (enc_out_valid),
    .enc_out_bit   (enc_out_bit),
    .m_valid       (m_valid),
    .m_bit         (m_bit),
    .m_ready       (m_ready),
    .m_sof         (m_sof),
    .m_eof         (m_eof),
    .m_id          (m_id),
    .err_stray     (err_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit          busy_m;
  int          in_cnt_m;
  int          out_cnt_m;
  int          ptr_m;
  bit          exp_err;
  logic [50:0] cur_data;
  logic [62:0] cur_cw;
  int          cur_id;
  int          frames_done;
  int          id_log[$];
  int          exp_ids[$];

  // requesters
  bit          req_on[N];
  bit          req_keep[N];
  logic [50:0] req_d[N];

  // behavioural encoder
  bit          out_q[$];
  int          emu_cnt;
  logic [50:0] emu_bits;

  // stimulus knobs
  bit          rnd_mode;
  bit          stray_now;
  int          mready_mode;
  bit          tog;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bch_parity(input logic [50:0] d);
    logic [62:0] r;
    r = {d, 12'b0};
    for (int i = 62; i >= 12; i--) begin
      if (r[i]) r[i-:13] = r[i-:13] ^ GPOLY;
    end
    return r[11:0];
  endfunction

  function automatic logic [N-1:0] model_pick(input logic [N-1:0] v, input int p);
    logic [N-1:0] oh;
    int start;
    oh = '0;
`ifdef BCH_SCHED_PRIORITY_EN
    start = 0;
`else
    start = p;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (v[i] && oh == '0) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  function automatic logic [50:0] rnd51();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[50:0];
  endfunction

  task automatic clear_model();
    busy_m    = 1'b0;
    in_cnt_m  = 0;
    out_cnt_m = 0;
    ptr_m     = 0;
    exp_err   = 1'b0;
    emu_cnt   = 0;
    emu_bits  = '0;
    out_q.delete();
    for (int i = 0; i < N; i++) req_on[i] = 1'b0;
  endtask

  // One clock: drive at negedge, sample #1 later, then advance to next negedge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] hs;
    logic [11:0]  p;
    bit           exp_mv;
    int           g;

    for (int i = 0; i < N; i++) begin
      req_valid[i]          = req_on[i];
      req_data[i*51 +: 51]  = req_d[i];
    end
    enc_ready_in = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (stray_now) begin
      enc_out_valid = 1'b1;
      enc_out_bit   = 1'b1;
    end else if (out_q.size() > 0 && (!rnd_mode || $urandom_range(0, 4) != 0)) begin
      enc_out_valid = 1'b1;
      enc_out_bit   = out_q[0];
    end else begin
      enc_out_valid = 1'b0;
      enc_out_bit   = 1'b0;
    end
    if (mready_mode == 1) begin
      m_ready = ($urandom_range(0, 3) != 0);
    end else if (mready_mode == 2 && busy_m && in_cnt_m >= 51) begin
      tog     = !tog;
      m_ready = tog;
    end else begin
      m_ready = 1'b1;
    end
    #1;

    exp_rdy = busy_m ? '0 : model_pick(req_valid, ptr_m);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("enc_ready_out", 64'(enc_ready_out), 64'(m_ready));
    chk("enc_valid", 64'(enc_valid), 64'(busy_m && in_cnt_m < 51));
    exp_mv = busy_m && enc_out_valid;
    chk("m_valid", 64'(m_valid), 64'(exp_mv));
    chk("err_stray", 64'(err_stray), 64'(exp_err));
    if (busy_m) begin
      chk("m_id", 64'(m_id), 64'(cur_id));
      chk("m_sof", 64'(m_sof), 64'(out_cnt_m == 0));
      chk("m_eof", 64'(m_eof), 64'(out_cnt_m == 62));
    end

    // behavioural encoder: systematic bits stream through, parity follows
    if (enc_valid && enc_ready_in) begin
      out_q.push_back(enc_bit);
      emu_bits = {emu_bits[49:0], enc_bit};
      emu_cnt++;
      if (emu_cnt == 51) begin
        p = bch_parity(emu_bits);
        for (int j = 11; j >= 0; j--) out_q.push_back(p[j]);
        emu_cnt = 0;
      end
    end
    if (!stray_now && enc_out_valid && m_ready && out_q.size() > 0) begin
      void'(out_q.pop_front());
    end

    if (!busy_m && enc_out_valid) exp_err = 1'b1;

    if (busy_m && in_cnt_m < 51 && enc_ready_in) begin
      chk("enc_bit", 64'(enc_bit), 64'(cur_data[50 - in_cnt_m]));
      in_cnt_m++;
    end

    if (exp_mv && m_ready) begin
      chk("m_bit", 64'(m_bit), 64'(cur_cw[62 - out_cnt_m]));
      if (out_cnt_m == 62) begin
        id_log.push_back(int'(m_id));
        frames_done++;
        busy_m = 1'b0;
      end else begin
        out_cnt_m++;
      end
    end

    hs = req_valid & exp_rdy;
    if (hs != '0) begin
      g = 0;
      for (int i = 0; i < N; i++) if (hs[i]) g = i;
      cur_data  = req_d[g];
      cur_cw    = {req_d[g], bch_parity(req_d[g])};
      cur_id    = g;
      busy_m    = 1'b1;
      in_cnt_m  = 0;
      out_cnt_m = 0;
      tog       = 1'b0;
      ptr_m     = (g + 1) % N;
      if (req_keep[g]) req_d[g] = rnd51();
      else req_on[g] = 1'b0;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frames(input int n, input string tag);
    int target;
    int budget;
    target = frames_done + n;
    budget = 0;
    while (frames_done < target && budget < 3000 * n) begin
      step();
      budget++;
    end
    chk({tag, "_frames_done"}, 64'(frames_done), 64'(target));
  endtask

  task automatic check_ids(input string tag);
    chk({tag, "_id_count"}, 64'(id_log.size()), 64'(exp_ids.size()));
    if (id_log.size() == exp_ids.size()) begin
      for (int i = 0; i < exp_ids.size(); i++) begin
        chk({tag, "_id_seq"}, 64'(id_log[i]), 64'(exp_ids[i]));
      end
    end
    $display("%s: ids=%p", tag, id_log);
    id_log.delete();
  endtask

  // Assert reset at the current negedge, check every output is cleared, then
  // release one cycle later with the model cleared to match.
  task automatic do_reset();
    rst           = 1'b0;
    req_valid     = '1;
    enc_out_valid = 1'b1;
    enc_out_bit   = 1'b1;
    m_ready       = 1'b1;
    enc_ready_in  = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_enc_valid", 64'(enc_valid), 64'd0);
    chk("rst_enc_bit", 64'(enc_bit), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_bit", 64'(m_bit), 64'd0);
    chk("rst_m_sof", 64'(m_sof), 64'd0);
    chk("rst_m_eof", 64'(m_eof), 64'd0);
    chk("rst_m_id", 64'(m_id), 64'd0);
    chk("rst_err_stray", 64'(err_stray), 64'd0);
    $display("reset: outputs checked while rst low");
    @(posedge clk);
    @(negedge clk);
    clear_model();
    enc_out_valid = 1'b0;
    enc_out_bit   = 1'b0;
    req_valid     = '0;
    rst           = 1'b1;
  endtask

  initial begin
    int budget;
    rst          = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    enc_ready_in = 1'b0;
    enc_out_valid= 1'b0;
    enc_out_bit  = 1'b0;
    m_ready      = 1'b0;
    rnd_mode     = 1'b0;
    stray_now    = 1'b0;
    mready_mode  = 0;
    tog          = 1'b0;
    frames_done  = 0;
    for (int i = 0; i < N; i++) begin
      req_keep[i] = 1'b0;
      req_d[i]    = '0;
    end
    clear_model();
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // single requester, alternating pattern, full-rate handshakes
    req_d[0]  = 51'h5_5555_5555_5555;
    req_on[0] = 1'b1;
    run_frames(1, "single_req0");
    exp_ids = '{0};
    check_ids("single_req0");

    // two requesters held valid for four codewords, random handshakes
    do_reset();
    rnd_mode    = 1'b1;
    mready_mode = 1;
    for (int i = 0; i < 2; i++) begin
      req_d[i]    = rnd51();
      req_on[i]   = 1'b1;
      req_keep[i] = 1'b1;
    end
    run_frames(4, "two_req");
    for (int i = 0; i < N; i++) begin
      req_on[i]   = 1'b0;
      req_keep[i] = 1'b0;
    end
`ifdef BCH_SCHED_PRIORITY_EN
    exp_ids = '{0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 0, 1};
`endif
    check_ids("two_req");

    // m_ready toggling while draining
    rnd_mode    = 1'b0;
    mready_mode = 2;
    req_d[1]    = rnd51();
    req_on[1]   = 1'b1;
    run_frames(1, "drain_toggle");
    exp_ids = '{1};
    check_ids("drain_toggle");

    // reset mid-codeword after 20 accepted data bits
    mready_mode = 0;
    req_d[2]    = rnd51();
    req_on[2]   = 1'b1;
    budget      = 0;
    while (!(busy_m && in_cnt_m == 20) && budget < 500) begin
      step();
      budget++;
    end
    chk("mid_reset_in_cnt", 64'(in_cnt_m), 64'd20);
    chk("mid_reset_m_id_before", 64'(m_id), 64'd2);
    id_log.delete();
    do_reset();
    rnd_mode  = 1'b1;
    req_d[1]  = rnd51();
    req_on[1] = 1'b1;
    run_frames(1, "after_reset");
    exp_ids = '{1};
    check_ids("after_reset");

    // stray encoder output while IDLE
    rnd_mode  = 1'b0;
    stray_now = 1'b1;
    step();
    stray_now = 1'b0;
    chk("stray_err_rise", 64'(err_stray), 64'd1);
    repeat (5) step();
    chk("stray_err_hold", 64'(err_stray), 64'd1);
    req_d[0]  = rnd51();
    req_on[0] = 1'b1;
    run_frames(1, "stray_frame");
    chk("stray_err_after_frame", 64'(err_stray), 64'd1);
    id_log.delete();
    do_reset();

    // pointer at 0 with requesters 1 and 2 pending
    rnd_mode    = 1'b1;
    mready_mode = 1;
    req_d[1]    = rnd51();
    req_d[2]    = rnd51();
    req_on[1]   = 1'b1;
    req_on[2]   = 1'b1;
    run_frames(2, "ptr_110");
    exp_ids = '{1, 2};
    check_ids("ptr_110");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bch_tx_scheduler.md
# bch_tx_scheduler

Shares one serial BCH(63,51) encoder between `N_REQ` block requesters. It grants one requester per codeword, serialises the granted 51-bit block MSB-first into the encoder, and counts the 63 encoded bits coming back. It forwards those bits downstream with frame markers and the requester ID. It sits between the framing sources and the encoder, ahead of the modulator, and owns the encoder's downstream-ready input.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `ID_W`, 3, width of `m_id`; must satisfy 2^`ID_W` ≥ `N_REQ`
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  requester i has a block ready
- `req_data`  in  N_REQ×51  block of requester i, bit 50 sent first
- `req_ready`  out  N_REQ  one-hot grant/accept strobe
- `enc_valid`  out  1  data bit valid toward encoder (encoder `valid_in`)
- `enc_bit`  out  1  data bit toward encoder (encoder `data_in`)
- `enc_ready_in`  in  1  encoder accepts a data bit (encoder `ready_in`)
- `enc_ready_out`  out  1  downstream ready passed to encoder (encoder `ready_out`)
- `enc_out_valid`  in  1  encoder output bit valid
- `enc_out_bit`  in  1  encoder output bit
- `m_valid`, `m_bit`  out  1,1  encoded stream to downstream
- `m_ready`  in  1  downstream accepts bit
- `m_sof`, `m_eof`  out  1,1  first / 63rd bit of codeword
- `m_id`  out  ID_W  requester owning current codeword
- `err_stray`  out  1  sticky flag: encoder output seen while IDLE

## Operation
- FSM states: IDLE, SHIFT, DRAIN.
- IDLE
  - Arbiter picks one asserted `req_valid`; `req_ready[g]` is high combinationally in the same cycle.
  - On handshake: latch `req_data[g]` into a 51-bit shift register; latch g into `m_id`; clear `in_cnt` and `out_cnt`; go to SHIFT.
- SHIFT
  - `enc_valid`=1 and `enc_bit`=`sh[50]`.
  - Each cycle with `enc_ready_in`: shift left and increment `in_cnt`.
  - When the 51st bit is accepted (`in_cnt`==50 with `enc_ready_in`), go to DRAIN.
- Output counting runs in SHIFT and DRAIN.
  - `m_valid` = `enc_out_valid` when state≠IDLE; `m_bit` = `enc_out_bit`.
  - Each `m_valid`&`m_ready` cycle increments `out_cnt`.
  - `m_sof` = (`out_cnt`==0); `m_eof` = (`out_cnt`==62).
- DRAIN: on eof handshake, go to IDLE. The next grant comes no earlier than the following cycle.
- `enc_ready_out` = `m_ready` in every state, so back-pressure reaches the encoder directly.
- Round-robin arbitration:
  - The pointer moves to g+1 (mod `N_REQ`) on each grant.
  - The search starts at the pointer.
  - Requests deasserted before grant are ignored; no request is latched early.
- `enc_out_valid` in IDLE: the bit is dropped (`m_valid` stays 0) and `err_stray` is set. `err_stray` clears only on reset.
- Counter widths: `in_cnt` 6 bits (0..50) and `out_cnt` 6 bits (0..62). Neither wraps; both clear on grant.

## Timing
- Reset values:
  - State IDLE, pointer 0.
  - `req_ready`=0 is the combinational result of `req_valid`=0 or reset.
  - `enc_valid`=0, `enc_bit`=0, `m_valid`=0, `m_bit`=0, `m_sof`=0, `m_eof`=0, `m_id`=0, `err_stray`=0.
- Grant-to-first `enc_valid`: 1 cycle.
- 51 data bits take at least 51 cycles at full `enc_ready_in`.
- Codeword issue interval is at least 63 output handshakes + 1 IDLE cycle.
- Reset mid-codeword: everything clears immediately; the partial codeword is abandoned. Downstream must discard any frame without `m_eof`.

## Configuration
- `BCH_SCHED_PRIORITY_EN`
  - Defined: strict fixed priority; the lowest index asserting `req_valid` always wins, and the pointer is unused.
  - Undefined: round-robin as above.

## Structure
- Shared `bch_pkg` holds:
  - `BCH_N`=63, `BCH_K`=51, `BCH_R`=12;
  - `bch_sched_state_t` enum {IDLE, SHIFT, DRAIN}.
- Sub-module `rr_arbiter`, parameterised by `N_REQ`:
  - inputs: `req` vector, pointer, enable;
  - outputs: one-hot grant and encoded index;
  - the priority variant is selected inside it under the macro.

## Test plan
- Single requester 0, `req_data`=51'h5_5555_5555_5555, `m_ready`=1:
  - 51 `enc_bit` values alternate 1,0,… starting with 1;
  - exactly 63 `m_valid` bits, `m_sof` on the 1st, `m_eof` on the 63rd, `m_id`=0.
- Requesters 0 and 1 both held valid for 4 codewords: `m_id` sequence 0,1,0,1.
  - With `BCH_SCHED_PRIORITY_EN`: 0,0,0,0.
- `m_ready` toggling 1,0,1,0 during DRAIN:
  - `enc_ready_out` mirrors `m_ready`;
  - exactly 63 accepted bits, none duplicated or lost.
- `rst` low at `in_cnt`=20 in SHIFT:
  - all outputs 0 during reset;
  - after release a new grant produces a complete 63-bit frame with `m_sof` on the first bit.
- `enc_out_valid`=1 forced for one cycle in IDLE: `m_valid` stays 0 and `err_stray` rises and stays 1 until reset.
- `N_REQ`=3 with `req_valid`=3'b110 and pointer 0: requester 1 is granted, then requester 2.
